mcu_spi_target: RTL and testbench
=================================

# mcu_spi_target

SPI target front end between the board MCU and the core's MCU-facing control blocks. It oversamples the MCU's SPI lines in the `clk` domain and assembles MOSI bytes. The first byte of each frame selects a destination block. Each following byte is delivered as a one-cycle strobe with a start flag on the command byte, which is the byte-stream format `sysctrl` and its sibling targets consume. Reply bytes from the selected target are shifted back on MISO one byte later.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronisers for `spi_ss_n`, `spi_sclk` and `spi_mosi`. Legal values are 2 or more.

Ports:
- `clk` in 1: core system clock. This is the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `spi_ss_n` in 1: MCU chip select, active low, asynchronous to `clk`.
- `spi_sclk` in 1: MCU SPI clock, mode 0, asynchronous.
- `spi_mosi` in 1: MCU data to the FPGA, MSB first.
- `spi_miso` out 1: FPGA data to the MCU, MSB first.
- `mcu_start` out 1: marks the current delivered byte as the command byte (first byte after the target byte).
- `mcu_dout` out 8: the delivered byte, shared by all targets.
- `mcu_sys_strobe`, `mcu_hid_strobe`, `mcu_osd_strobe`, `mcu_sdc_strobe` out 1 each: per-target byte-valid pulses.
- `mcu_sys_din`, `mcu_hid_din`, `mcu_osd_din`, `mcu_sdc_din` in 8 each: reply byte from each target.

## Operation
- Synchronise each SPI input through `SYNC_STAGES` flip-flops. Detect `spi_sclk` rise and fall by comparing the synchronised value with its previous value.
- Frame states:
  - IDLE: `spi_ss_n` is high.
  - TARGET: the synchronised `ss_n` has fallen.
  - COMMAND: entered after the target byte completes.
  - DATA: entered after the command byte; stays in DATA until `ss_n` rises.
- On each sclk rise with `ss_n` low: `rx <= {rx[6:0], mosi}` and the 3-bit bit counter increments. A count wrapping 7→0 completes a byte.
- Byte completion in TARGET: latch the target id.
  - 0x01 = sys, 0x02 = hid, 0x03 = osd, 0x04 = sdc.
  - Any other id is "none". No strobes fire for the rest of the frame, and replies are 0x00.
  - No strobe fires for the target byte itself.
- Byte completion in COMMAND or DATA: `mcu_dout <= byte`, the selected strobe pulses for one cycle, and `mcu_start` = 1 only in COMMAND, otherwise 0.
- MISO drives `tx[7]`. On each sclk fall, `tx <= {tx[6:0], 0}`.
  - Exactly 2 cycles after any byte completion, `tx` loads the selected target's `*_din`, or 0x00 when the target is none or the frame is still in TARGET. This gives the target one cycle to register its reply.
  - Net effect: the reply to byte N is shifted out during byte N+1.
- `spi_ss_n` rising at any time returns the block to IDLE and clears the bit counter and `tx`. A partial byte is discarded with no strobe. The next frame starts fresh in TARGET.
- An sclk edge detected while `ss_n` is high is ignored.

## Timing
- Reset values: `spi_miso` = 0, `mcu_start` = 0, `mcu_dout` = 0x00, all strobes = 0, state = IDLE, bit counter = 0, target id = none.
- Input latency: an SPI pin edge is seen internally `SYNC_STAGES` + 1 cycles later.
- Strobe timing: a strobe is asserted in the cycle after the 8th rising edge is detected and lasts exactly one cycle. `mcu_dout` and `mcu_start` are valid in that cycle and hold until the next byte completion.
- MISO timing: MISO changes no later than `SYNC_STAGES` + 2 cycles after the pin-level sclk fall.
- Host constraints:
  - sclk high and low phases are each at least `SYNC_STAGES` + 3 clk cycles.
  - The gap from `ss_n` falling to the first sclk rise is at least the same.
  - The first MISO bit of byte N+1 must be valid before its first sclk rise, so the host inter-byte gap is at least 4 clk cycles after the 8th rise.
- Strobes are mutually exclusive, with at most one per byte.
- Simultaneous events: if a byte completion and an `ss_n` rise are detected in the same cycle, `ss_n` wins and no strobe fires.

## Structure
- Package `mcu_spi_pkg`: target-id constants `TGT_SYS` = 0x01, `TGT_HID` = 0x02, `TGT_OSD` = 0x03, `TGT_SDC` = 0x04; the frame-state enum (IDLE, TARGET, COMMAND, DATA); and the target-select enum.
- Sub-module `spi_sync_edge`: an N-stage synchroniser that outputs `level`, `rise` and `fall`. It is instantiated three times, one per SPI input.

## Test plan
- **Routing:** frame 0x01, 0x05, 0x10 → one `mcu_sys_strobe` with `mcu_start` = 1 and `mcu_dout` = 0x05, then one with `mcu_start` = 0 and `mcu_dout` = 0x10. No other strobes fire.
- **Reply path:** frame 0x01, 0x00, 0xFF, 0xFF, 0xFF with a sysctrl-like bench model returning 0x5C, 0x42, 0x03 → MISO byte 0 reads 0x00, and bytes 3 and 4 read 0x5C and 0x42.
- **Unknown target:** frame 0x07, 0x00, 0x12 → no strobes, and MISO reads all 0x00.
- **Abort:** `ss_n` raised after 5 bits of the command byte, then a new frame 0x02, 0x33 → no strobe for the partial byte, then `mcu_hid_strobe` with `mcu_start` = 1 and `mcu_dout` = 0x33.
- **Reset mid-frame:** `reset_n` pulsed low asynchronously mid-DATA → all outputs return to reset values immediately, and a subsequent frame decodes correctly.
- **Minimum sclk timing:** sclk at the minimum legal phase length with `SYNC_STAGES` = 3 → every byte decodes correctly and MISO bits are stable at each sclk rise.

Source files
------------

// File: rtl/mcu_spi_pkg.sv
// rtl/mcu_spi_pkg.sv - shared constants and types for the MCU SPI target
package mcu_spi_pkg;

    localparam logic [7:0] TGT_SYS = 8'h01;
    localparam logic [7:0] TGT_HID = 8'h02;
    localparam logic [7:0] TGT_OSD = 8'h03;
    localparam logic [7:0] TGT_SDC = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TARGET,
        ST_COMMAND,
        ST_DATA
    } frame_state_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_SYS,
        SEL_HID,
        SEL_OSD,
        SEL_SDC
    } tgt_sel_e;

    // Map a received target byte onto a destination; anything unknown is "none"
    function automatic tgt_sel_e decode_target(input logic [7:0] id);
        tgt_sel_e sel;
        sel = SEL_NONE;
        case (id)
            TGT_SYS: sel = SEL_SYS;
            TGT_HID: sel = SEL_HID;
            TGT_OSD: sel = SEL_OSD;
            TGT_SDC: sel = SEL_SDC;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage synchroniser with rise/fall detection
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the asynchronous pin through the chain and keep the last settled level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/mcu_spi_target.sv
// rtl/mcu_spi_target.sv - oversampled SPI target routing MCU bytes to control blocks
module mcu_spi_target
    import mcu_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_ss_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       mcu_start,
    output logic [7:0] mcu_dout,
    output logic       mcu_sys_strobe,
    output logic       mcu_hid_strobe,
    output logic       mcu_osd_strobe,
    output logic       mcu_sdc_strobe,
    input  logic [7:0] mcu_sys_din,
    input  logic [7:0] mcu_hid_din,
    input  logic [7:0] mcu_osd_din,
    input  logic [7:0] mcu_sdc_din
);

    logic ss_level, ss_rise, ss_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    // Chip select idles high, so its synchroniser resets high to avoid a false frame start
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi_ss_n),
        .level_o (ss_level),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi_sclk),
        .level_o (sclk_level),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi_mosi),
        .level_o (mosi_level),
        .rise_o  (mosi_rise),
        .fall_o  (mosi_fall)
    );

    // ss_rise implies ss_level, so the level alone drives the abort path
    logic unused_sync;
    assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall, ss_rise};

    frame_state_e state_q, state_d;
    tgt_sel_e     tgt_q, tgt_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   rx_q, rx_d;
    logic [7:0]   tx_q, tx_d;
    logic [7:0]   dout_q, dout_d;
    logic         start_q, start_d;
    logic [3:0]   strobe_q, strobe_d;
    logic         load1_q, load1_d, load2_q, load2_d;
    logic         zero1_q, zero1_d, zero2_q, zero2_d;

    logic         in_frame, bit_rx, byte_done;
    logic [7:0]   rx_byte;
    logic [7:0]   reply;
    logic [3:0]   stb_sel;

    // Reply source and strobe bit for the currently latched target
    always_comb begin
        reply   = 8'h00;
        stb_sel = 4'b0000;
        case (tgt_q)
            SEL_SYS: begin reply = mcu_sys_din; stb_sel = 4'b0001; end
            SEL_HID: begin reply = mcu_hid_din; stb_sel = 4'b0010; end
            SEL_OSD: begin reply = mcu_osd_din; stb_sel = 4'b0100; end
            SEL_SDC: begin reply = mcu_sdc_din; stb_sel = 4'b1000; end
            default: begin reply = 8'h00;       stb_sel = 4'b0000; end
        endcase
    end

    assign in_frame  = (state_q != ST_IDLE);
    assign bit_rx    = in_frame && !ss_level && sclk_rise;
    assign byte_done = bit_rx && (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_q[6:0], mosi_level};

    // Frame sequencing, byte assembly, delivery and MISO shifter next-state
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        dout_d    = dout_q;
        start_d   = start_q;
        strobe_d  = 4'b0000;
        load1_d   = 1'b0;
        load2_d   = load1_q;
        zero1_d   = 1'b0;
        zero2_d   = zero1_q;

        if (state_q == ST_IDLE && ss_fall) begin
            state_d   = ST_TARGET;
            tgt_d     = SEL_NONE;
            bit_cnt_d = 3'd0;
            rx_d      = 8'h00;
        end

        if (bit_rx) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if (byte_done) begin
            load1_d = 1'b1;
            zero1_d = (state_q == ST_TARGET);
            case (state_q)
                ST_TARGET: begin
                    tgt_d   = decode_target(rx_byte);
                    state_d = ST_COMMAND;
                end
                ST_COMMAND: begin
                    dout_d   = rx_byte;
                    start_d  = 1'b1;
                    strobe_d = stb_sel;
                    state_d  = ST_DATA;
                end
                ST_DATA: begin
                    dout_d   = rx_byte;
                    start_d  = 1'b0;
                    strobe_d = stb_sel;
                end
                default: ;
            endcase
        end

        // The fall that ends a byte (count already wrapped to 0) must not shift,
        // otherwise it would discard the MSB of the freshly loaded reply.
        if (load2_q) begin
            tx_d = zero2_q ? 8'h00 : reply;
        end else if (in_frame && !ss_level && sclk_fall && bit_cnt_q != 3'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
        end

        // Deselect overrides everything, including a byte completing this cycle
        if (ss_level) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            tx_d      = 8'h00;
            strobe_d  = 4'b0000;
            load1_d   = 1'b0;
            load2_d   = 1'b0;
            zero1_d   = 1'b0;
            zero2_d   = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            tgt_q     <= SEL_NONE;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            dout_q    <= 8'h00;
            start_q   <= 1'b0;
            strobe_q  <= 4'b0000;
            load1_q   <= 1'b0;
            load2_q   <= 1'b0;
            zero1_q   <= 1'b0;
            zero2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            dout_q    <= dout_d;
            start_q   <= start_d;
            strobe_q  <= strobe_d;
            load1_q   <= load1_d;
            load2_q   <= load2_d;
            zero1_q   <= zero1_d;
            zero2_q   <= zero2_d;
        end
    end

    assign spi_miso       = tx_q[7];
    assign mcu_start      = start_q;
    assign mcu_dout       = dout_q;
    assign mcu_sys_strobe = strobe_q[0];
    assign mcu_hid_strobe = strobe_q[1];
    assign mcu_osd_strobe = strobe_q[2];
    assign mcu_sdc_strobe = strobe_q[3];

endmodule

// File: tb/tb_mcu_spi_target.sv
// tb/tb_mcu_spi_target.sv - directed scoreboard bench for mcu_spi_target
module tb_mcu_spi_target;

    localparam int S  = 3;
    localparam int PH = S + 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_ss_n = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       mcu_start;
    logic [7:0] mcu_dout;
    logic       mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe;
    logic [7:0] mcu_sys_din;
    logic [7:0] mcu_hid_din = 8'hA5;
    logic [7:0] mcu_osd_din = 8'h3C;
    logic [7:0] mcu_sdc_din = 8'h99;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];
    logic [12:0] exp_item;
    logic [3:0]  stb_obs;
    logic [7:0]  mi;
    int          sys_idx;

    mcu_spi_target #(.SYNC_STAGES(S)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .spi_ss_n       (spi_ss_n),
        .spi_sclk       (spi_sclk),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .mcu_start      (mcu_start),
        .mcu_dout       (mcu_dout),
        .mcu_sys_strobe (mcu_sys_strobe),
        .mcu_hid_strobe (mcu_hid_strobe),
        .mcu_osd_strobe (mcu_osd_strobe),
        .mcu_sdc_strobe (mcu_sdc_strobe),
        .mcu_sys_din    (mcu_sys_din),
        .mcu_hid_din    (mcu_hid_din),
        .mcu_osd_din    (mcu_osd_din),
        .mcu_sdc_din    (mcu_sdc_din)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sys_resp(input int idx);
        case (idx)
            0:       return 8'h5C;
            1:       return 8'h42;
            2:       return 8'h03;
            default: return 8'h00;
        endcase
    endfunction

    // sysctrl-like target: command byte clears the reply, data bytes step a reply table
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcu_sys_din <= 8'h00;
            sys_idx     <= 0;
        end else if (mcu_sys_strobe) begin
            if (mcu_start) begin
                mcu_sys_din <= 8'h00;
                sys_idx     <= 0;
            end else begin
                mcu_sys_din <= sys_resp(sys_idx);
                sys_idx     <= sys_idx + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pop the scoreboard on every delivered byte
    always @(negedge clk) begin
        stb_obs = {mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe};
        if (stb_obs != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("strobe_unexpected", {19'd0, stb_obs, mcu_start, mcu_dout}, 32'd0);
            end else begin
                exp_item = exp_q.pop_front();
                check("strobe_byte", {19'd0, stb_obs, mcu_start, mcu_dout}, {19'd0, exp_item});
            end
        end
    end

    task automatic expect_byte(input logic [3:0] stb, input logic start, input logic [7:0] d);
        exp_q.push_back({stb, start, d});
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] m);
        m = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            repeat (PH) @(negedge clk);
            m[i] = spi_miso;
            spi_sclk = 1'b1;
            repeat (PH) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        spi_ss_n = 1'b0;
    endtask

    task automatic frame_end();
        repeat (PH) @(negedge clk);
        spi_ss_n = 1'b1;
        repeat (3 * PH) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_miso", {31'd0, spi_miso}, 32'd0);
        check("rst_start", {31'd0, mcu_start}, 32'd0);
        check("rst_dout", {24'd0, mcu_dout}, 32'd0);
        check("rst_strobes", {28'd0, mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Routing to sys
        frame_begin();
        send_bits(8'h01, 8, mi);
        expect_byte(4'b0001, 1'b1, 8'h05);
        send_bits(8'h05, 8, mi);
        expect_byte(4'b0001, 1'b0, 8'h10);
        send_bits(8'h10, 8, mi);
        frame_end();

        // Reply path through the sys model
        frame_begin();
        send_bits(8'h01, 8, mi);
        check("reply_b0", {24'd0, mi}, 32'h00);
        expect_byte(4'b0001, 1'b1, 8'h00);
        send_bits(8'h00, 8, mi);
        check("reply_b1", {24'd0, mi}, 32'h00);
        expect_byte(4'b0001, 1'b0, 8'hFF);
        send_bits(8'hFF, 8, mi);
        check("reply_b2", {24'd0, mi}, 32'h00);
        expect_byte(4'b0001, 1'b0, 8'hFF);
        send_bits(8'hFF, 8, mi);
        check("reply_b3", {24'd0, mi}, 32'h5C);
        expect_byte(4'b0001, 1'b0, 8'hFF);
        send_bits(8'hFF, 8, mi);
        check("reply_b4", {24'd0, mi}, 32'h42);
        frame_end();

        // Unknown target: no strobes, MISO silent
        frame_begin();
        send_bits(8'h07, 8, mi);
        check("unk_b0", {24'd0, mi}, 32'h00);
        send_bits(8'h00, 8, mi);
        check("unk_b1", {24'd0, mi}, 32'h00);
        send_bits(8'h12, 8, mi);
        check("unk_b2", {24'd0, mi}, 32'h00);
        frame_end();

        // Abort after 5 bits of the command byte, then a clean hid frame
        frame_begin();
        send_bits(8'h02, 8, mi);
        send_bits(8'h77, 5, mi);
        frame_end();
        frame_begin();
        send_bits(8'h02, 8, mi);
        expect_byte(4'b0010, 1'b1, 8'h33);
        send_bits(8'h33, 8, mi);
        check("hid_b1_miso", {24'd0, mi}, 32'h00);
        expect_byte(4'b0010, 1'b0, 8'h00);
        send_bits(8'h00, 8, mi);
        check("hid_b2_miso", {24'd0, mi}, 32'hA5);
        frame_end();

        // Asynchronous reset in the middle of a DATA byte
        frame_begin();
        send_bits(8'h04, 8, mi);
        expect_byte(4'b1000, 1'b1, 8'h11);
        send_bits(8'h11, 8, mi);
        send_bits(8'hAA, 3, mi);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
        check("mid_rst_start", {31'd0, mcu_start}, 32'd0);
        check("mid_rst_dout", {24'd0, mcu_dout}, 32'd0);
        check("mid_rst_strobes", {28'd0, mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        frame_end();

        // Frame after reset decodes and replies normally
        frame_begin();
        send_bits(8'h03, 8, mi);
        expect_byte(4'b0100, 1'b1, 8'h21);
        send_bits(8'h21, 8, mi);
        expect_byte(4'b0100, 1'b0, 8'h22);
        send_bits(8'h22, 8, mi);
        check("osd_b2_miso", {24'd0, mi}, 32'h3C);
        frame_end();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
